spi_pkt_buf: RTL and testbench

- Parametrised successor to the single-buffer SPI transmit controller.
- Sits between the SPI slave shifter and the CPU bus, and provides separate TX and RX packet buffers of depth 2^ADDR_W.
- On each SPI packet it streams TX bytes to the shifter, padding with FILL once the programmed length is exhausted, and captures every received byte into the RX buffer.
- At packet end it reports received count, done, overflow and an interrupt.

---
 rtl/spi_pkt_buf.sv | 158 +++++++++++++++
 tb/tb_spi_pkt_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pkt_buf.sv
// SPI packet buffer: streams CPU-loaded TX bytes to the shifter, padding with FILL,
// and captures every received byte into an RX buffer readable over the CPU bus.
module spi_pkt_buf #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 5,
  parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_pkt_start,
  input  logic              rx_pkt_end,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  input  logic              tx_full_clr,
  input  logic [ADDR_W:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  output logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic              irq
);

  // state | meaning
  // IDLE  | no packet in progress
  // LOAD  | present next TX byte (or FILL) to the shifter
  // WAIT  | TX byte presented, waiting for the next received byte
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  localparam int             DEPTH   = 1 << ADDR_W;
  localparam int             AW1     = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_V = AW1'(DEPTH);

  state_t state, state_d;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];

  logic [ADDR_W:0]   tx_len, len_q, tx_idx, rx_cnt, tx_len_sat;
  logic [ADDR_W:0]   addr_q;
  logic              done, overflow, busy, irq_en;
  logic              start_ev, load_ev, store_ev, ovf_ev, end_ev;
  logic              reg_wr, stat_wr;
  logic [ADDR_W-1:0] reg_off, rx_waddr;
  logic              unused_rd;

  assign unused_rd  = cpu_rd;
  assign reg_wr     = cpu_wr & cpu_addr[ADDR_W];
  assign reg_off    = cpu_addr[ADDR_W-1:0];
  assign stat_wr    = reg_wr && (reg_off == ADDR_W'(2));
  assign tx_len_sat = (32'(cpu_di) > 32'(DEPTH)) ? DEPTH_V : cpu_di[ADDR_W:0];
  assign rx_waddr   = start_ev ? '0 : rx_cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    start_ev = 1'b0;
    load_ev  = 1'b0;
    store_ev = 1'b0;
    ovf_ev   = 1'b0;
    end_ev   = 1'b0;
    if (rx_valid && rx_pkt_start) begin
      start_ev = 1'b1;
      state_d  = LOAD;
    end else begin
      case (state)
        LOAD: begin
          load_ev = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (rx_valid) begin
            if (rx_cnt < DEPTH_V) store_ev = 1'b1;
            else                  ovf_ev   = 1'b1;
            state_d = LOAD;
          end
        end
        default: ;
      endcase
      // End of packet overrides a pending load; the received byte is still kept.
      if (rx_pkt_end && busy) begin
        end_ev  = 1'b1;
        load_ev = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= '0;
      tx_full  <= 1'b0;
      irq      <= 1'b0;
      tx_len   <= '0;
      len_q    <= '0;
      tx_idx   <= '0;
      rx_cnt   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      irq_en   <= 1'b0;
      addr_q   <= '0;
    end else begin
      addr_q <= cpu_addr;
      irq    <= done & irq_en;
      if (reg_wr && (reg_off == ADDR_W'(0))) tx_len <= tx_len_sat;
      if (reg_wr && (reg_off == ADDR_W'(3))) irq_en <= cpu_di[0];
      if (stat_wr && cpu_di[0]) done     <= 1'b0;
      if (stat_wr && cpu_di[2]) overflow <= 1'b0;
      if (tx_full_clr) tx_full <= 1'b0;
      if (start_ev) begin
        len_q   <= tx_len;
        tx_idx  <= '0;
        rx_cnt  <= AW1'(1);
        busy    <= 1'b1;
        tx_full <= 1'b0;
      end
      if (load_ev) begin
        tx_data <= (tx_idx < len_q) ? tx_mem[tx_idx[ADDR_W-1:0]] : FILL;
        tx_full <= 1'b1;
        if (tx_idx < len_q) tx_idx <= tx_idx + AW1'(1);
      end
      if (store_ev) rx_cnt   <= rx_cnt + AW1'(1);
      if (ovf_ev)   overflow <= 1'b1;
      if (end_ev) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        tx_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && cpu_wr && !cpu_addr[ADDR_W]) tx_mem[cpu_addr[ADDR_W-1:0]] <= cpu_di;
    if (!reset && (start_ev || store_ev))      rx_mem[rx_waddr] <= rx_data;
  end

  always_comb begin
    cpu_do = '0;
    if (!addr_q[ADDR_W]) begin
      cpu_do = rx_mem[addr_q[ADDR_W-1:0]];
    end else begin
      case (addr_q[ADDR_W-1:0])
        ADDR_W'(0): cpu_do[ADDR_W:0] = tx_len;
        ADDR_W'(1): cpu_do[ADDR_W:0] = rx_cnt;
        ADDR_W'(2): cpu_do[2:0]      = {overflow, busy, done};
        ADDR_W'(3): cpu_do[0]        = irq_en;
        default:    cpu_do           = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pkt_buf.sv
// Directed bench for spi_pkt_buf: TX streaming, RX capture, overflow, restart, reset.
module tb_spi_pkt_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid, rx_pkt_start, rx_pkt_end, tx_full_clr;
  logic [7:0] rx_data, tx_data, cpu_di, cpu_do;
  logic       tx_full, cpu_wr, cpu_rd, irq;
  logic [5:0] cpu_addr;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] A_TXLEN = 6'd32, A_RXCNT = 6'd33, A_STAT = 6'd34,
                         A_CTRL = 6'd35, A_UNUSED = 6'd36;

  spi_pkt_buf dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .tx_data(tx_data),
    .tx_full(tx_full), .tx_full_clr(tx_full_clr), .cpu_addr(cpu_addr),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_di = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [7:0] d);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    d = cpu_do;
    cpu_rd = 1'b0;
  endtask

  // One received byte; returns the TX byte the controller loaded in response, then the shifter takes it.
  task automatic send_byte(input logic [7:0] d, input logic st, output logic [7:0] txd, output logic txf);
    rx_valid = 1'b1; rx_pkt_start = st; rx_data = d;
    tick();
    rx_valid = 1'b0; rx_pkt_start = 1'b0;
    tick();
    txd = tx_data; txf = tx_full;
    tx_full_clr = 1'b1;
    tick();
    tx_full_clr = 1'b0;
  endtask

  task automatic send_end();
    rx_pkt_end = 1'b1;
    tick();
    rx_pkt_end = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    cpu_read(A_TXLEN, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_tx_len: got %h expected 00", r); end
    cpu_read(A_RXCNT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_rx_cnt: got %h expected 00", r); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", r); end
    cpu_read(A_CTRL, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", r); end
  endtask

  task automatic test_tx_len_sat();
    logic [7:0] r;
    cpu_write(A_TXLEN, 8'd50);
    cpu_read(A_TXLEN, r);
    checks++; if (r !== 8'd32) begin errors++; $display("FAIL txlen_sat50: got %0d expected 32", r); end
    cpu_write(A_TXLEN, 8'd32);
    cpu_read(A_TXLEN, r);
    checks++; if (r !== 8'd32) begin errors++; $display("FAIL txlen_32: got %0d expected 32", r); end
    cpu_write(A_TXLEN, 8'd33);
    cpu_read(A_TXLEN, r);
    checks++; if (r !== 8'd32) begin errors++; $display("FAIL txlen_sat33: got %0d expected 32", r); end
    cpu_read(A_UNUSED, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL unused_offset: got %h expected 00", r); end
  endtask

  task automatic test_basic_packet();
    logic [7:0]  r, txd, exp;
    logic        txf;
    logic [23:0] tv = 24'hC3B2A1;
    cpu_write(A_TXLEN, 8'd3);
    cpu_read(A_TXLEN, r);
    checks++; if (r !== 8'd3) begin errors++; $display("FAIL txlen_3: got %0d expected 3", r); end
    cpu_write(6'd0, 8'hA1);
    cpu_write(6'd1, 8'hB2);
    cpu_write(6'd2, 8'hC3);
    cpu_write(A_CTRL, 8'h01);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i), i == 0, txd, txf);
      exp = (i < 3) ? tv[i*8 +: 8] : 8'hFF;
      checks++; if (txd !== exp || txf !== 1'b1) begin errors++; $display("FAIL basic_tx[%0d]: got %h full=%b expected %h full=1", i, txd, txf, exp); end
    end
    send_end();
    cpu_read(A_RXCNT, r);
    checks++; if (r !== 8'd5) begin errors++; $display("FAIL basic_rx_cnt: got %0d expected 5", r); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h01) begin errors++; $display("FAIL basic_status: got %h expected 01", r); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b expected 1", irq); end
    for (int i = 0; i < 5; i++) begin
      cpu_read(6'(i), r);
      checks++; if (r !== 8'h10 + 8'(i)) begin errors++; $display("FAIL basic_rx[%0d]: got %h expected %h", i, r, 8'h10 + 8'(i)); end
    end
    cpu_write(A_STAT, 8'h01);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clr_irq_lag: got %b expected 1", irq); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL clr_done: got %h expected 00", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_zero_len();
    logic [7:0] r, txd;
    logic       txf;
    cpu_write(A_TXLEN, 8'd0);
    send_byte(8'h55, 1'b1, txd, txf);
    checks++; if (txd !== 8'hFF) begin errors++; $display("FAIL zlen_tx0: got %h expected FF", txd); end
    send_byte(8'h66, 1'b0, txd, txf);
    checks++; if (txd !== 8'hFF) begin errors++; $display("FAIL zlen_tx1: got %h expected FF", txd); end
    send_end();
    cpu_read(6'd0, r);
    checks++; if (r !== 8'h55) begin errors++; $display("FAIL zlen_rx0: got %h expected 55", r); end
    cpu_read(6'd1, r);
    checks++; if (r !== 8'h66) begin errors++; $display("FAIL zlen_rx1: got %h expected 66", r); end
    cpu_read(A_RXCNT, r);
    checks++; if (r !== 8'd2) begin errors++; $display("FAIL zlen_rx_cnt: got %0d expected 2", r); end
    cpu_write(A_STAT, 8'h01);
  endtask

  task automatic test_overflow();
    logic [7:0] r, txd;
    logic       txf;
    cpu_write(A_TXLEN, 8'd2);
    for (int i = 0; i < 35; i++) send_byte(8'h40 + 8'(i), i == 0, txd, txf);
    send_end();
    cpu_read(A_RXCNT, r);
    checks++; if (r !== 8'd32) begin errors++; $display("FAIL ovf_rx_cnt: got %0d expected 32", r); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h05) begin errors++; $display("FAIL ovf_status: got %h expected 05", r); end
    cpu_read(6'd31, r);
    checks++; if (r !== 8'h5F) begin errors++; $display("FAIL ovf_rx31: got %h expected 5F", r); end
    cpu_read(6'd0, r);
    checks++; if (r !== 8'h40) begin errors++; $display("FAIL ovf_rx0: got %h expected 40", r); end
    cpu_write(A_STAT, 8'h05);
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL ovf_clear: got %h expected 00", r); end
  endtask

  task automatic test_restart();
    logic [7:0] r, txd;
    logic       txf;
    cpu_write(A_TXLEN, 8'd3);
    send_byte(8'h70, 1'b1, txd, txf);
    send_byte(8'h71, 1'b0, txd, txf);
    checks++; if (txd !== 8'hB2) begin errors++; $display("FAIL rst_pre_tx: got %h expected B2", txd); end
    send_byte(8'h80, 1'b1, txd, txf);
    checks++; if (txd !== 8'hA1) begin errors++; $display("FAIL restart_tx0: got %h expected A1", txd); end
    cpu_read(A_RXCNT, r);
    checks++; if (r !== 8'd1) begin errors++; $display("FAIL restart_rx_cnt: got %0d expected 1", r); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h02) begin errors++; $display("FAIL restart_status: got %h expected 02", r); end
    cpu_read(6'd0, r);
    checks++; if (r !== 8'h80) begin errors++; $display("FAIL restart_rx0: got %h expected 80", r); end
    send_byte(8'h81, 1'b0, txd, txf);
    checks++; if (txd !== 8'hB2) begin errors++; $display("FAIL restart_tx1: got %h expected B2", txd); end
    send_end();
    cpu_write(A_STAT, 8'h01);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    // Shifter clear lands in the LOAD cycle: the load must win.
    rx_valid = 1'b1; rx_pkt_start = 1'b1; rx_data = 8'h90;
    tick();
    rx_valid = 1'b0; rx_pkt_start = 1'b0; tx_full_clr = 1'b1;
    tick();
    tx_full_clr = 1'b0;
    checks++; if (tx_full !== 1'b1 || tx_data !== 8'hA1) begin errors++; $display("FAIL load_vs_clr: got full=%b data=%h expected full=1 data=A1", tx_full, tx_data); end
    tx_full_clr = 1'b1;
    tick();
    tx_full_clr = 1'b0;
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL clr_in_wait: got %b expected 0", tx_full); end
    // CPU clear of done collides with the hardware set at packet end.
    cpu_addr = A_STAT; cpu_di = 8'h01; cpu_wr = 1'b1; rx_pkt_end = 1'b1;
    tick();
    cpu_wr = 1'b0; rx_pkt_end = 1'b0;
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h01) begin errors++; $display("FAIL set_wins_clr: got %h expected 01", r); end
    cpu_write(A_STAT, 8'h01);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_lag: got %b expected 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL b2b_irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] r;
    rx_valid = 1'b1; rx_pkt_start = 1'b1; rx_data = 8'hA0;
    tick();
    rx_valid = 1'b0; rx_pkt_start = 1'b0;
    tick();
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL mid_pre_full: got %b expected 1", tx_full); end
    reset = 1'b1;
    tick();
    checks++; if (tx_full !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got full=%b data=%h irq=%b expected 0/00/0", tx_full, tx_data, irq); end
    reset = 1'b0;
    cpu_read(A_TXLEN, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL mid_tx_len: got %h expected 00", r); end
    cpu_read(A_CTRL, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL mid_ctrl: got %h expected 00", r); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL mid_status: got %h expected 00", r); end
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_data = 8'hB0 + 8'(i);
      tick();
      rx_valid = 1'b0;
      tick();
    end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL mid_ignore_full: got %b expected 0", tx_full); end
    cpu_read(A_RXCNT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL mid_ignore_cnt: got %h expected 00", r); end
    cpu_read(A_STAT, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL mid_ignore_stat: got %h expected 00", r); end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_pkt_start = 1'b0; rx_pkt_end = 1'b0;
    tx_full_clr = 1'b0; cpu_addr = '0; cpu_di = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    test_reset();
    test_tx_len_sat();
    test_basic_packet();
    test_zero_len();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
